// File: rtl/result_writeback.sv
// result_writeback: buffers controller memory writes in a small FIFO and
// issues them one at a time to memory with a req/ack handshake.
// Optional feature macro: SYSTOLIC_WB_PERF_EN adds the drained_count
// performance counter port.
//
// Handshake: mem_req stays high while an entry is pending; mem_addr and
// mem_wdata show the FIFO head and hold stable until the cycle where
// mem_ack=1 is sampled on a rising edge, which retires that entry.
module result_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic signed [WIDTH-1:0]    wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic signed [WIDTH-1:0]    mem_wdata,
  input  logic                       mem_ack,
  input  logic                       flush,
  output logic                       flush_done
`ifdef SYSTOLIC_WB_PERF_EN
  ,
  output logic [31:0]                drained_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]       addr_mem [DEPTH];
  logic signed [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    flush_pend;
  logic                    push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_valid && !full;
  assign pop   = (state == ISSUE) && mem_ack;

  // Entry storage; contents are only observable through the head, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, sticky overflow and pending-flush bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_valid && full) overflow <= 1'b1;
      flush_pend <= flush | (flush_pend & ~flush_done);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: issue whenever something is queued, idle once drained.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (count != '0 || push) state_next = ISSUE;
      ISSUE: if (pop && count == CW'(1) && !push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: head entry is presented only while a request is active.
  always_comb begin
    mem_req    = (state == ISSUE);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_req) begin
      mem_addr  = addr_mem[rd_ptr];
      mem_wdata = data_mem[rd_ptr];
    end
    flush_done = flush_pend && empty && (state == IDLE);
  end

`ifdef SYSTOLIC_WB_PERF_EN
  // Retired-write counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      drained_count <= '0;
    else if (pop) drained_count <= drained_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_result_writeback.sv
// Testbench for result_writeback: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_result_writeback;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_valid;
  logic [ADDR_W-1:0]       wr_addr;
  logic signed [WIDTH-1:0] wr_data;
  logic                    full, empty, overflow, mem_req, mem_ack, flush, flush_done;
  logic [CW-1:0]           count;
  logic [ADDR_W-1:0]       mem_addr;
  logic signed [WIDTH-1:0] mem_wdata;
`ifdef SYSTOLIC_WB_PERF_EN
  logic [31:0]             drained_count;
`endif

  always #5 clk = ~clk;

  result_writeback #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .flush(flush), .flush_done(flush_done)
`ifdef SYSTOLIC_WB_PERF_EN
    , .drained_count(drained_count)
`endif
  );

  // ---------------- reference model ----------------
  // Buffer contents as a plain queue of {addr, data}; a request is pending
  // exactly when something is queued; flush completes once the queue is empty.
  logic [ADDR_W+WIDTH-1:0] exp_q[$];
  bit          m_ovf     = 0;
  bit          m_pend    = 0;
  int unsigned m_drained = 0;
  int          checks    = 0;
  int          failures  = 0;
  int          dut_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [ADDR_W-1:0] ea;
    logic [WIDTH-1:0]  ed;
    logic [WIDTH-1:0]  od;
    int sz;
    sz = exp_q.size();
    if (sz != 0) {ea, ed} = exp_q[0];
    else begin ea = '0; ed = '0; end
    od = mem_wdata;
    if (flush_done === 1'b1) dut_pulses++;
    chk("mem_req",    32'(mem_req),    32'(sz != 0));
    chk("empty",      32'(empty),      32'(sz == 0));
    chk("full",       32'(full),       32'(sz == DEPTH));
    chk("count",      32'(count),      32'(sz));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("flush_done", 32'(flush_done), 32'(m_pend && sz == 0));
    chk("mem_addr",   32'(mem_addr),   32'(ea));
    chk("mem_wdata",  32'(od),         32'(ed));
`ifdef SYSTOLIC_WB_PERF_EN
    chk("drained_count", drained_count, m_drained);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, advance the model across the rising
  // edge, then check at the next falling edge.
  task automatic cycle(input logic wv, input logic [ADDR_W-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic ack, input logic fl);
    bit push, pop, done;
    int sz;
    wr_valid = wv; wr_addr = wa; wr_data = wd; mem_ack = ack; flush = fl;
    @(posedge clk);
    sz   = exp_q.size();
    done = m_pend && sz == 0;
    push = wv && sz < DEPTH;
    pop  = ack && sz != 0;
    if (wv && sz == DEPTH) m_ovf = 1;
    m_pend = fl || (m_pend && !done);
    if (pop) begin
      void'(exp_q.pop_front());
      m_drained++;
    end
    if (push) exp_q.push_back({wa, wd});
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from any clock edge and checks outputs immediately.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    wr_valid = 1'b0; mem_ack = 1'b0; flush = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 0; m_pend = 0; m_drained = 0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; mem_ack = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    idle(2);

    // Single push with ack held high: request next cycle, retired after.
    cycle(1'b1, 12'h010, -16'sd5, 1'b1, 1'b0);
    chk("s1_addr", 32'(mem_addr), 32'h010);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("s1_empty", 32'(empty), 32'd1);
    idle(2);

    // Nine pushes without acks: last one dropped, overflow sticks.
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 12'(i + 12'h100), 16'($urandom), 1'b0, 1'b0);
    chk("s2_full", 32'(full), 32'd1);
    chk("s2_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("s2_order", 32'(mem_addr), 32'(i + 12'h100));
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("s2_overflow", 32'(overflow), 32'd1);
    do_reset();

    // Push and ack in the same cycle at count=3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'(i + 12'h200), 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 12'h2a0, 16'($urandom), 1'b1, 1'b0);
    chk("s3_count", 32'(count), 32'd3);
    chk("s3_addr", 32'(mem_addr), 32'h201);
    idle(1);
    do_reset();

    // Flush with four queued entries, ack every other cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'($urandom), 16'($urandom), 1'b0, 1'b0);
    dut_pulses = 0;
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'(i % 2), 1'b0);
    idle(4);
    chk("s4_pulses", 32'(dut_pulses), 32'd1);

    // Reset mid-operation with five entries queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'($urandom), 16'($urandom), 1'b0, 1'b0);
    chk("s5_req_before", 32'(mem_req), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Six retired writes.
    for (int i = 0; i < 6; i++) cycle(1'b1, 12'($urandom), 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
`ifdef SYSTOLIC_WB_PERF_EN
    chk("s6_drained", drained_count, 32'd6);
`endif

    // Random traffic: a fill-heavy phase then a drain-heavy phase.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 12'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) == 0), 12'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width (signed).
REQ-002 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-003 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid  input  1  controller write strobe (controller's mem_write).
REQ-007 SHALL have port wr_addr  input  ADDR_W  controller write address (act_addr).
REQ-008 SHALL have port wr_data  input  WIDTH  signed controller write data (mem_data_write).
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-013 SHALL have port mem_req  output  1  memory write request.
REQ-014 SHALL have port mem_addr  output  ADDR_W  address of the FIFO head entry.
REQ-015 SHALL have port mem_wdata  output  WIDTH  data of the FIFO head entry.
REQ-016 SHALL have port mem_ack  input  1  memory accepted the current request.
REQ-017 SHALL have port flush  input  1  request to drain all pending writes.
REQ-018 SHALL have port flush_done  output  1  one-cycle pulse when a flush completes.
REQ-019 SHALL have port drained_count  output  32  writes retired to memory; present only under the Configuration macro.

Function
REQ-020 SHALL push {wr_addr, wr_data} on a rising edge where wr_valid=1 and full=0; data is stored unmodified.
REQ-021 SHALL drop a write where wr_valid=1 and full=1, even if a pop happens in the same cycle, and SHALL set overflow.
REQ-022 SHALL, on a simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL implement the FSM with states IDLE and ISSUE.
REQ-025 SHALL move from IDLE to ISSUE on the edge where count is nonzero, or where a push is accepted.
REQ-026 SHALL drive mem_req=1 exactly while in ISSUE, with mem_addr and mem_wdata equal to the head entry and held stable until mem_ack.
REQ-027 SHALL, in ISSUE with mem_ack=1, pop the head; the FSM stays in ISSUE if entries remain after the pop and any same-cycle push, otherwise it returns to IDLE.
REQ-028 SHALL ignore mem_ack in IDLE.
REQ-029 SHALL give a latency of one cycle from an accepted push into an empty IDLE buffer to mem_req=1 with that entry.
REQ-030 SHALL latch a pending-flush bit when flush=1.
REQ-031 SHALL pulse flush_done for one cycle on the first cycle where a flush is pending, the FIFO is empty and the FSM is IDLE, and SHALL then clear the pending bit.
REQ-032 SHALL accept pushes during a pending flush and SHALL delay flush_done until those entries have drained.

Reset
REQ-033 SHALL, on rst=1 asynchronously, clear pointers, count, overflow, the pending-flush bit and drained_count, and enter IDLE.
REQ-034 SHALL drive these output values during reset: mem_req=0, flush_done=0, empty=1, full=0, count=0, overflow=0, mem_addr=0, mem_wdata=0.
REQ-035 SHALL discard in-flight and queued writes when reset is asserted mid-operation, with no retry after reset.

Configuration
REQ-036 SHALL use the macro SYSTOLIC_WB_PERF_EN to control the performance counter.
- Defined: drained_count increments on each mem_ack pop and wraps at 2^32.
- Undefined: the drained_count port and its counter are absent; all other behaviour is identical.

Verification
REQ-037 SHALL cover this scenario: one push (addr 0x010, data -5) into an empty buffer, mem_ack held high -> mem_req=1 next cycle with 0x010/-5, empty=1 after the ack, FSM back in IDLE.
REQ-038 SHALL cover this scenario: 9 pushes with DEPTH=8 and mem_ack=0 -> full=1, count=8, overflow=1, 9th write absent; 8 acks then retire the first 8 in order.
REQ-039 SHALL cover this scenario: push and ack in the same cycle at count=3 -> count stays 3, mem_addr advances to the next entry.
REQ-040 SHALL cover this scenario: flush with 4 entries queued, one ack every other cycle -> flush_done pulses exactly once, one cycle after the 4th ack.
REQ-041 SHALL cover this scenario: rst asserted while mem_req=1 with 5 entries queued -> mem_req=0 immediately, count=0, no further requests.
REQ-042 SHALL cover this scenario: with SYSTOLIC_WB_PERF_EN defined, 6 retired writes -> drained_count=6; without the macro the build has no drained_count port.
